// File: rtl/adc_capture_ram_writer.sv
// Purpose : arms on a pulse, waits for a software or rising-edge external trigger,
//           then packs pairs of sign-extended ADC samples into 32-bit words and
//           writes a fixed-length record to consecutive words of RAM port s2.
// Latency : one RAM write in the cycle after each odd-phase sample; DONE follows
//           one cycle after the last write.
// Backpressure: none; s2 has no waitrequest, so every write is accepted.
//           adc_valid gaps simply stall the packing.
// Ports   : clk/reset (sync, active-high); adc_data/adc_valid sample stream;
//           arm/abort pulses, sw_trigger level, ext_trigger (edge), capture_len;
//           ram_* to the s2 slave; armed/busy/done status; words_written count.
module adc_capture_ram_writer #(
    parameter int ADDR_W      = 19,
    parameter int DEPTH_WORDS = 393216,
    parameter int SAMPLE_W    = 14,
    parameter int BASE_WORD   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                arm,
    input  logic                abort,
    input  logic                sw_trigger,
    input  logic                ext_trigger,
    input  logic [ADDR_W-1:0]   capture_len,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [3:0]          ram_byteenable,
    output logic [31:0]         ram_writedata,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   words_written
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    // DEPTH_WORDS must be representable in ADDR_W bits for the length compare.
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_WORD);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   words_q, words_d;
    logic [15:0]         hold_q, hold_d;
    logic                phase_q, phase_d;
    logic                ext_trigger_q, ext_trigger_d;
    logic                ram_write_q, ram_write_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [31:0]         ram_writedata_q, ram_writedata_d;
    logic                armed_q, armed_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                trig;
    logic [15:0]         sample_sx;
    logic [ADDR_W-1:0]   len_sel;

    assign sample_sx = 16'($signed(adc_data));
    assign trig      = sw_trigger | (ext_trigger & ~ext_trigger_q);
    // Zero or oversize lengths fall back to the whole RAM.
    assign len_sel   = ((capture_len == '0) || (32'(capture_len) > DEPTH_WORDS))
                       ? DEPTH_L : capture_len;

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        words_d         = words_q;
        hold_d          = hold_q;
        phase_d         = phase_q;
        ext_trigger_d   = ext_trigger;
        ram_write_d     = 1'b0;
        ram_address_d   = '0;
        ram_writedata_d = '0;

        case (state_q)
            IDLE: begin
                if (!abort && arm) begin
                    state_d = ARMED;
                    len_d   = len_sel;
                    words_d = '0;
                    phase_d = 1'b0;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (trig) begin
                    state_d = CAPTURE;
                end else if (arm) begin
                    len_d   = len_sel;
                    words_d = '0;
                    phase_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    // Any held even-phase sample is dropped.
                    state_d = IDLE;
                    phase_d = 1'b0;
                end else if (words_q == len_q) begin
                    // Last word went out in the previous cycle.
                    state_d = DONE;
                end else if (adc_valid) begin
                    if (!phase_q) begin
                        hold_d  = sample_sx;
                        phase_d = 1'b1;
                    end else begin
                        phase_d         = 1'b0;
                        ram_write_d     = 1'b1;
                        ram_address_d   = BASE_L + words_q;
                        ram_writedata_d = {sample_sx, hold_q};
                        words_d         = words_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (arm) begin
                    state_d = ARMED;
                    len_d   = len_sel;
                    words_d = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state.
        armed_d = (state_d == ARMED);
        busy_d  = (state_d == CAPTURE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            len_q           <= DEPTH_L;
            words_q         <= '0;
            hold_q          <= '0;
            phase_q         <= 1'b0;
            ext_trigger_q   <= 1'b0;
            ram_write_q     <= 1'b0;
            ram_address_q   <= '0;
            ram_writedata_q <= '0;
            armed_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            words_q         <= words_d;
            hold_q          <= hold_d;
            phase_q         <= phase_d;
            ext_trigger_q   <= ext_trigger_d;
            ram_write_q     <= ram_write_d;
            ram_address_q   <= ram_address_d;
            ram_writedata_q <= ram_writedata_d;
            armed_q         <= armed_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign ram_address    = ram_address_q;
    assign ram_chipselect = ram_write_q;
    assign ram_write      = ram_write_q;
    assign ram_byteenable = 4'hF;
    assign ram_writedata  = ram_writedata_q;
    assign armed          = armed_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_adc_capture_ram_writer.sv
// Purpose : drives adc_capture_ram_writer with directed sequences and random
//           sample data, comparing every cycle against a record-level reference.
// Ports   : none (top-level bench).
module tb_adc_capture_ram_writer;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SW = 14;
    localparam int BW = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sw_trigger = 1'b0;
    logic          ext_trigger = 1'b0;
    logic [AW-1:0] capture_len = '0;
    logic [AW-1:0] ram_address;
    logic          ram_chipselect;
    logic          ram_write;
    logic [3:0]    ram_byteenable;
    logic [31:0]   ram_writedata;
    logic          armed;
    logic          busy;
    logic          done;
    logic [AW-1:0] words_written;

    adc_capture_ram_writer #(
        .ADDR_W(AW), .DEPTH_WORDS(DW), .SAMPLE_W(SW), .BASE_WORD(BW)
    ) dut (
        .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .sw_trigger(sw_trigger), .ext_trigger(ext_trigger),
        .capture_len(capture_len), .ram_address(ram_address),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .armed(armed), .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: record mode, latched length, words emitted, accepted samples.
    int   m_mode;      // 0 idle, 1 armed, 2 capturing, 3 done
    int   m_len;
    int   m_words;
    int   q[$];
    logic m_ext_prev;

    logic [31:0] obs_data [0:DW-1];
    int          last_addr;
    int          n_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(16383, 0)) - 8192;
    endfunction

    task automatic start_record();
        m_len   = (capture_len == 0 || int'(capture_len) > DW) ? DW : int'(capture_len);
        m_words = 0;
        q.delete();
    endtask

    task automatic cyc(input logic a, input logic ab, input logic sw, input logic ex,
                       input logic v, input int d);
        logic        trig;
        logic        exp_wr;
        logic [31:0] ew;
        logic [AW-1:0] ea;
        arm = a; abort = ab; sw_trigger = sw; ext_trigger = ex;
        adc_valid = v; adc_data = SW'(d);
        @(posedge clk); #1;
        trig = sw | (ex & ~m_ext_prev);
        m_ext_prev = ex;
        exp_wr = 1'b0; ew = '0; ea = '0;
        case (m_mode)
            0: if (!ab && a) begin start_record(); m_mode = 1; end
            1: if (ab) m_mode = 0;
               else if (trig) m_mode = 2;
               else if (a) start_record();
            2: if (ab) m_mode = 0;
               else if (m_words == m_len) m_mode = 3;
               else if (v) begin
                   q.push_back(d);
                   if (q.size() % 2 == 0) begin
                       exp_wr = 1'b1;
                       ea = AW'(BW + m_words);
                       ew = {16'(q[q.size()-1]), 16'(q[q.size()-2])};
                       m_words++;
                   end
               end
            default: if (ab) m_mode = 0;
                     else if (a) begin start_record(); m_mode = 1; end
        endcase
        check("ram_write", ram_write, exp_wr);
        check("ram_chipselect", ram_chipselect, exp_wr);
        if (ram_write === 1'b1) n_wr++;
        if (exp_wr) begin
            check("ram_address", ram_address, ea);
            check("ram_writedata", ram_writedata, ew);
            obs_data[ea] = ram_writedata;
            last_addr = int'(ram_address);
        end
        check("status_abd", {armed, busy, done}, {m_mode == 1, m_mode == 2, m_mode == 3});
        check("words_written", words_written, AW'(m_words));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input logic v, input int d);
        reset = 1'b1; arm = 0; abort = 0; sw_trigger = 0; ext_trigger = 0;
        adc_valid = v; adc_data = SW'(d);
        @(posedge clk); #1;
        reset = 1'b0;
        m_mode = 0; m_words = 0; q.delete(); m_ext_prev = 1'b0;
        check("rst_ram_write", {ram_write, ram_chipselect}, 2'b00);
        check("rst_ram_address", ram_address, '0);
        check("rst_ram_writedata", ram_writedata, '0);
        check("rst_byteenable", ram_byteenable, 4'hF);
        check("rst_status", {armed, busy, done}, 3'b000);
        check("rst_words", words_written, '0);
    endtask

    initial begin
        int v;
        int wr0;
        m_mode = 0; m_len = DW; m_words = 0; m_ext_prev = 1'b0; n_wr = 0; last_addr = -1;

        // Reset state.
        do_reset(1'b0, 0);
        idle(2);

        // Length 4, back-to-back samples 1,-1,2,-2,...
        capture_len = AW'(4);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? (i / 2 + 1) : -(i / 2 + 1);
            cyc(0, 0, 0, 0, 1, v);
        end
        idle(3);
        check("t1_word0", obs_data[0], 32'hFFFF_0001);
        check("t1_word1", obs_data[1], 32'hFFFE_0002);
        check("t1_last_addr", last_addr, 3);
        check("t1_done_words", {done, words_written}, {1'b1, AW'(4)});

        // Sparse valid (every 3rd cycle), length 2; trigger-cycle sample ignored.
        capture_len = AW'(2);
        wr0 = n_wr;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, rnd_sample());
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, (i % 3 == 2), rnd_sample());
        check("t2_write_count", n_wr - wr0, 2);

        // External trigger held across arm must not fire; a new edge does.
        capture_len = AW'(3);
        wr0 = n_wr;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, rnd_sample());
        check("t3_still_armed", {armed, n_wr - wr0}, {1'b1, 32'd0});
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, rnd_sample());
        check("t3_write_count", n_wr - wr0, 3);

        // Length 0 means the whole RAM (16 words here); random valid gaps.
        idle(1);
        capture_len = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300 && m_words < DW; i++)
            cyc(0, 0, 0, 0, ($urandom_range(3, 0) != 0), rnd_sample());
        cyc(0, 0, 0, 0, 1, rnd_sample());
        check("t4_last_addr", last_addr, DW - 1);
        check("t4_done_words", {done, words_written}, {1'b1, AW'(DW)});

        // Arm from DONE, then abort beats trigger, then arm+abort in IDLE.
        capture_len = AW'(2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check("t5_idle", {armed, busy, done}, 3'b000);

        // Abort after three samples: one write, the held half-word is lost.
        wr0 = n_wr;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, rnd_sample());
        cyc(0, 1, 0, 0, 1, rnd_sample());
        idle(2);
        check("t5_abort_writes", n_wr - wr0, 1);
        check("t5_abort_done", done, 1'b0);
        last_addr = -1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, rnd_sample());
        check("t5_restart_last_addr", last_addr, 1);

        // Reset in the middle of a capture, with an odd sample pending.
        capture_len = AW'(4);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, rnd_sample());
        wr0 = n_wr;
        do_reset(1'b1, rnd_sample());
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, rnd_sample());
        check("t6_no_writes_after_reset", n_wr - wr0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, rnd_sample());
        check("t6_recapture", {done, words_written}, {1'b1, AW'(4)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
